// File: rtl/ped_request_conditioner.sv
// Pedestrian button conditioner: synchronise, debounce, then turn each clean press into a
// latched request with pulse strobe, ack handshake and a saturating press counter.
module ped_request_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             btn_raw,
    input  logic             req_ack,
    output logic             btn_level,
    output logic             req_pulse,
    output logic             req_pending,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q;
    logic                   pending_q, pending_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   accept;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync_out != level_q) begin
            if (db_cnt_q == DB_MAX) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // A press is accepted only on the edge where the debounced level rises with ena high.
    assign accept = ena && !level_q && level_d;

    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (req_ack) begin
            pending_d = 1'b0;
        end
        count_d = count_q;
        if (accept && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            pulse_q   <= accept;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign btn_level   = level_q;
    assign req_pulse   = pulse_q;
    assign req_pending = pending_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Directed bench for ped_request_conditioner: default instance plus a small-counter instance
// (CNT_W=2, DEBOUNCE_CYCLES=4) for saturation.
module tb_ped_request_conditioner;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       btn_raw;
    logic       req_ack;
    logic       btn_level;
    logic       req_pulse;
    logic       req_pending;
    logic [7:0] press_count;

    logic       s_ena;
    logic       s_btn;
    logic       s_ack;
    logic       s_level;
    logic       s_pulse;
    logic       s_pending;
    logic [1:0] s_count;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int spulses = 0;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    ped_request_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .btn_raw    (btn_raw),
        .req_ack    (req_ack),
        .btn_level  (btn_level),
        .req_pulse  (req_pulse),
        .req_pending(req_pending),
        .press_count(press_count)
    );

    ped_request_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (2)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .ena        (s_ena),
        .btn_raw    (s_btn),
        .req_ack    (s_ack),
        .btn_level  (s_level),
        .req_pulse  (s_pulse),
        .req_pending(s_pending),
        .press_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each edge and tallying strobes.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pulses  += int'(req_pulse);
            spulses += int'(s_pulse);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; btn_raw = 1'b1; req_ack = 1'b0;
        s_ena = 1'b1; s_btn = 1'b0; s_ack = 1'b0;

        // Reset held with button high
        run(3);
        check("rst_level", btn_level, 0);
        check("rst_pulse", req_pulse, 0);
        check("rst_pending", req_pending, 0);
        check("rst_count", press_count, 0);

        rst = 1'b0;
        pulses = 0;
        run(17);
        check("lat_level_e17", btn_level, 0);
        run(1);
        check("lat_level_e18", btn_level, 1);
        check("press_pulse", req_pulse, 1);
        check("press_pending", req_pending, 1);
        check("press_count1", press_count, 1);
        run(1);
        check("pulse_one_cycle", req_pulse, 0);

        // Ack clears pending
        req_ack = 1'b1;
        run(1);
        req_ack = 1'b0;
        check("ack_clear", req_pending, 0);

        // Held button: still only one accept
        run(20);
        check("held_one_pulse", pulses, 1);

        // Release: falling level after 18 edges, no event
        btn_raw = 1'b0;
        pulses = 0;
        run(17);
        check("rel_level_e17", btn_level, 1);
        run(1);
        check("rel_level_e18", btn_level, 0);
        check("rel_no_pulse", pulses, 0);
        check("rel_count", press_count, 1);

        // Bounce rejection
        btn_raw = 1'b1; run(10);
        btn_raw = 1'b0; run(3);
        btn_raw = 1'b1; run(10);
        check("bounce_level_mid", btn_level, 0);
        btn_raw = 1'b0; run(30);
        check("bounce_level", btn_level, 0);
        check("bounce_pulses", pulses, 0);
        check("bounce_count", press_count, 1);
        check("bounce_pending", req_pending, 0);

        // Second press, then third press aligned with ack
        btn_raw = 1'b1; run(18);
        check("p2_count", press_count, 2);
        check("p2_pending", req_pending, 1);
        btn_raw = 1'b0; run(25);
        btn_raw = 1'b1; run(17);
        req_ack = 1'b1;
        run(1);
        req_ack = 1'b0;
        check("align_pending", req_pending, 1);
        check("align_pulse", req_pulse, 1);
        check("align_count", press_count, 3);

        // Merge into an already pending request
        btn_raw = 1'b0; run(25);
        btn_raw = 1'b1; run(18);
        check("merge_pulse", req_pulse, 1);
        check("merge_pending", req_pending, 1);
        check("merge_count", press_count, 4);

        // Enable gating
        btn_raw = 1'b0; run(25);
        ena = 1'b0;
        pulses = 0;
        btn_raw = 1'b1; run(25);
        check("ena0_level", btn_level, 1);
        check("ena0_pulses", pulses, 0);
        check("ena0_count", press_count, 4);
        check("ena0_pending_hold", req_pending, 1);
        req_ack = 1'b1;
        run(1);
        req_ack = 1'b0;
        check("ena0_ack_clear", req_pending, 0);
        ena = 1'b1;
        run(5);
        check("ena_raise_pulses", pulses, 0);
        check("ena_raise_count", press_count, 4);
        check("ena_raise_pending", req_pending, 0);
        btn_raw = 1'b0; run(25);
        btn_raw = 1'b1; run(18);
        check("ena_repress_pulse", req_pulse, 1);
        check("ena_repress_count", press_count, 5);

        // Asynchronous reset mid-handshake, before any clock edge
        rst = 1'b1;
        #2;
        check("arst_pending", req_pending, 0);
        check("arst_count", press_count, 0);
        check("arst_level", btn_level, 0);
        btn_raw = 1'b0;
        run(2);
        rst = 1'b0;
        run(2);

        // Saturation on the 2-bit instance (latency 2+4 edges)
        for (int i = 0; i < 5; i++) begin
            spulses = 0;
            s_btn = 1'b1;
            run(5);
            check("sat_level_early", s_level, 0);
            run(1);
            check("sat_count", s_count, exp_sat[i]);
            check("sat_pulse", s_pulse, 1);
            s_btn = 1'b0;
            run(10);
            check("sat_one_pulse", spulses, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
